// File: rtl/retire_trace_uart_pkg.sv
// Shared types and constants for the retire-trace UART port.
// Frame layout: sync byte, then PC and instruction word, most significant byte first.
package trace_pkg;

    localparam logic [7:0] SYNC_BYTE   = 8'hA5;
    localparam int         FRAME_BYTES = 9;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } retire_rec_t;

    // Byte idx of the frame built from rec; index 0 is the sync byte.
    function automatic logic [7:0] frame_byte(input retire_rec_t rec, input logic [3:0] idx);
        logic [7:0] b;
        case (idx)
            4'd1:    b = rec.pc[31:24];
            4'd2:    b = rec.pc[23:16];
            4'd3:    b = rec.pc[15:8];
            4'd4:    b = rec.pc[7:0];
            4'd5:    b = rec.instr[31:24];
            4'd6:    b = rec.instr[23:16];
            4'd7:    b = rec.instr[15:8];
            4'd8:    b = rec.instr[7:0];
            default: b = SYNC_BYTE;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serialiser. byte_ready is also high in the last cycle of the stop bit,
// so a byte offered then starts on the very next clock with no idle gap.
module uart_tx_byte
    import trace_pkg::*;
#(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       byte_valid,
    input  logic [7:0] byte_data,
    output logic       byte_ready,
    output logic       tx
);

    localparam int             CW       = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]  CNT_LAST = CW'(CLKS_PER_BIT - 1);

    tx_state_t     state;
    tx_state_t     state_next;
    logic [CW-1:0] bit_cnt;
    logic [CW-1:0] bit_cnt_next;
    logic [2:0]    bit_idx;
    logic [2:0]    bit_idx_next;
    logic [7:0]    shifter;
    logic [7:0]    shifter_next;
    logic          tx_next;
    logic          bit_done;

    assign bit_done   = (bit_cnt == CNT_LAST);
    assign byte_ready = (state == IDLE) || ((state == STOP) && bit_done);

    always_comb begin
        state_next   = state;
        bit_cnt_next = bit_done ? '0 : bit_cnt + 1'b1;
        bit_idx_next = bit_idx;
        shifter_next = shifter;
        tx_next      = tx;
        if (byte_valid && byte_ready) begin
            state_next   = START;
            bit_cnt_next = '0;
            bit_idx_next = '0;
            shifter_next = byte_data;
            tx_next      = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    bit_cnt_next = '0;
                    tx_next      = 1'b1;
                end
                START: begin
                    if (bit_done) begin
                        state_next = DATA;
                        tx_next    = shifter[0];
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        if (bit_idx == 3'd7) begin
                            state_next = STOP;
                            tx_next    = 1'b1;
                        end else begin
                            bit_idx_next = bit_idx + 3'd1;
                            shifter_next = {1'b0, shifter[7:1]};
                            tx_next      = shifter[1];
                        end
                    end
                end
                STOP: begin
                    if (bit_done) begin
                        state_next = IDLE;
                    end
                end
                default: begin
                    state_next   = IDLE;
                    bit_cnt_next = '0;
                    tx_next      = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            bit_cnt <= '0;
            bit_idx <= '0;
            tx      <= 1'b1;
        end else begin
            state   <= state_next;
            bit_cnt <= bit_cnt_next;
            bit_idx <= bit_idx_next;
            tx      <= tx_next;
        end
    end

    always_ff @(posedge clk) begin
        shifter <= shifter_next;
    end

endmodule

// File: rtl/retire_trace.sv
// Retire-trace port: captures {pc, instr} at writeback and sends it as a 9-byte
// UART frame, with one pending slot and a saturating count of dropped retirements.
module retire_trace_uart
    import trace_pkg::*;
#(
    parameter int CLK_HZ       = 12_000_000,
    parameter int BAUD         = 115_200,
    parameter int CLKS_PER_BIT = CLK_HZ / BAUD
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        retire_valid,
    input  logic [31:0] retire_pc,
    input  logic [31:0] retire_instr,
    output logic        tx,
    output logic        busy,
    output logic [7:0]  drop_count
);

    localparam logic [3:0] LAST_IDX = 4'(FRAME_BYTES - 1);

    retire_rec_t in_rec;
    retire_rec_t active_rec;
    retire_rec_t pend_rec;

    logic       frame_active;
    logic       frame_active_next;
    logic [3:0] byte_idx;
    logic [3:0] byte_idx_next;
    logic       tail;
    logic       tail_next;
    logic       pend_valid;
    logic       pend_valid_next;
    logic [7:0] drop_next;
    logic       load_active;
    logic       load_from_pend;
    logic       load_pend;

    logic       byte_valid;
    logic [7:0] byte_data;
    logic       byte_ready;
    logic       handoff;
    logic       frame_end;

    assign in_rec = '{pc: retire_pc, instr: retire_instr};

    // In the tail (last byte handed over) the only byte worth offering is the
    // next frame's sync byte, and only if a frame is waiting in the pending slot.
    assign byte_valid = frame_active && (!tail || pend_valid);
    assign byte_data  = tail ? SYNC_BYTE : frame_byte(active_rec, byte_idx);
    assign handoff    = byte_valid && byte_ready;
    assign frame_end  = frame_active && tail && byte_ready;
    assign busy       = frame_active || pend_valid;

    always_comb begin
        frame_active_next = frame_active;
        byte_idx_next     = byte_idx;
        tail_next         = tail;
        pend_valid_next   = pend_valid;
        drop_next         = drop_count;
        load_active       = 1'b0;
        load_from_pend    = 1'b0;
        load_pend         = 1'b0;
        if (!frame_active) begin
            if (retire_valid) begin
                frame_active_next = 1'b1;
                byte_idx_next     = '0;
                tail_next         = 1'b0;
                load_active       = 1'b1;
            end
        end else if (frame_end) begin
            if (pend_valid) begin
                // Sync byte of the pending frame is handed off this cycle.
                byte_idx_next   = 4'd1;
                tail_next       = 1'b0;
                load_from_pend  = 1'b1;
                pend_valid_next = retire_valid;
                load_pend       = retire_valid;
            end else if (retire_valid) begin
                byte_idx_next = '0;
                tail_next     = 1'b0;
                load_active   = 1'b1;
            end else begin
                frame_active_next = 1'b0;
                byte_idx_next     = '0;
                tail_next         = 1'b0;
            end
        end else begin
            if (handoff) begin
                if (byte_idx == LAST_IDX) begin
                    tail_next = 1'b1;
                end else begin
                    byte_idx_next = byte_idx + 4'd1;
                end
            end
            if (retire_valid) begin
                if (!pend_valid) begin
                    load_pend       = 1'b1;
                    pend_valid_next = 1'b1;
                end else if (drop_count != 8'hFF) begin
                    drop_next = drop_count + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_active <= 1'b0;
            byte_idx     <= '0;
            tail         <= 1'b0;
            pend_valid   <= 1'b0;
            drop_count   <= '0;
        end else begin
            frame_active <= frame_active_next;
            byte_idx     <= byte_idx_next;
            tail         <= tail_next;
            pend_valid   <= pend_valid_next;
            drop_count   <= drop_next;
        end
    end

    always_ff @(posedge clk) begin
        if (load_active) begin
            active_rec <= in_rec;
        end else if (load_from_pend) begin
            active_rec <= pend_rec;
        end
        if (load_pend) begin
            pend_rec <= in_rec;
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx (
        .clk       (clk),
        .rst_n     (rst_n),
        .byte_valid(byte_valid),
        .byte_data (byte_data),
        .byte_ready(byte_ready),
        .tx        (tx)
    );

endmodule

// File: tb/tb_retire_trace_uart.sv
// Directed bench for retire_trace_uart with CLKS_PER_BIT = 4 (40 clocks per byte,
// 360 clocks per frame); tx is logged every falling edge and decoded afterwards.
module tb_retire_trace_uart;

    logic        clk;
    logic        rst_n;
    logic        retire_valid;
    logic [31:0] retire_pc;
    logic [31:0] retire_instr;
    logic        tx;
    logic        busy;
    logic [7:0]  drop_count;

    int n_vec = 0;
    int n_bad = 0;
    logic txlog[$];

    retire_trace_uart #(
        .CLKS_PER_BIT(4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .retire_valid(retire_valid),
        .retire_pc   (retire_pc),
        .retire_instr(retire_instr),
        .tx          (tx),
        .busy        (busy),
        .drop_count  (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) txlog.push_back(tx);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
            $error("%s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One-cycle retirement; returns 1 ns after the capturing edge.
    task automatic pulse(input logic [31:0] pc, input logic [31:0] instr);
        retire_pc    = pc;
        retire_instr = instr;
        retire_valid = 1'b1;
        tick();
        retire_valid = 1'b0;
    endtask

    function automatic int find_start();
        for (int i = 0; i < txlog.size(); i++) begin
            if (txlog[i] === 1'b0) return i;
        end
        return -1;
    endfunction

    function automatic int count_zeros(input int from);
        int n;
        n = 0;
        for (int i = from; i < txlog.size(); i++) begin
            if (txlog[i] !== 1'b1) n++;
        end
        return n;
    endfunction

    task automatic check_frame(input string tag, input int base, input logic [31:0] pc,
                               input logic [31:0] instr);
        logic [7:0] exp_b [9];
        logic [7:0] got;
        int b;
        exp_b[0] = 8'hA5;
        exp_b[1] = pc[31:24];
        exp_b[2] = pc[23:16];
        exp_b[3] = pc[15:8];
        exp_b[4] = pc[7:0];
        exp_b[5] = instr[31:24];
        exp_b[6] = instr[23:16];
        exp_b[7] = instr[15:8];
        exp_b[8] = instr[7:0];
        for (int k = 0; k < 9; k++) begin
            b = base + 40 * k;
            got = '0;
            for (int j = 0; j < 8; j++) got[j] = txlog[b + 6 + 4 * j];
            chk($sformatf("%s_start%0d", tag, k), {31'd0, txlog[b + 2]}, 32'd0);
            chk($sformatf("%s_byte%0d", tag, k), {24'd0, got}, {24'd0, exp_b[k]});
            chk($sformatf("%s_stop%0d", tag, k), {31'd0, txlog[b + 38]}, 32'd1);
        end
    endtask

    int s;

    initial begin
        rst_n        = 1'b0;
        retire_valid = 1'b0;
        retire_pc    = '0;
        retire_instr = '0;

        // Reset and idle
        repeat (3) tick();
        rst_n = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick();
            chk("idle_tx", {31'd0, tx}, 32'd1);
            chk("idle_busy", {31'd0, busy}, 32'd0);
            chk("idle_drop", {24'd0, drop_count}, 32'd0);
        end

        // Single retire: latency, frame content, busy duration
        txlog.delete();
        pulse(32'h0000_0004, 32'h0050_0093);
        chk("single_tx_at_E", {31'd0, tx}, 32'd1);
        chk("single_busy_at_E", {31'd0, busy}, 32'd1);
        tick();
        chk("single_tx_E1", {31'd0, tx}, 32'd0);
        repeat (359) tick();
        chk("single_busy_E360", {31'd0, busy}, 32'd1);
        tick();
        chk("single_busy_E361", {31'd0, busy}, 32'd0);
        chk("single_tx_E361", {31'd0, tx}, 32'd1);
        repeat (5) tick();
        s = find_start();
        chk("single_found", {31'd0, s >= 0}, 32'd1);
        if (s < 0) s = 0;
        check_frame("single", s, 32'h0000_0004, 32'h0050_0093);

        // Two retires 10 clocks apart: back-to-back frames
        txlog.delete();
        pulse(32'h0000_0000, 32'h0000_0013);
        repeat (9) tick();
        pulse(32'h0000_0004, 32'h0010_0093);
        chk("two_busy", {31'd0, busy}, 32'd1);
        repeat (740) tick();
        chk("two_drop", {24'd0, drop_count}, 32'd0);
        chk("two_busy_end", {31'd0, busy}, 32'd0);
        s = find_start();
        chk("two_found", {31'd0, s >= 0}, 32'd1);
        if (s < 0) s = 0;
        check_frame("two_f0", s, 32'h0000_0000, 32'h0000_0013);
        chk("two_last_stop", {31'd0, txlog[s + 359]}, 32'd1);
        chk("two_no_gap", {31'd0, txlog[s + 360]}, 32'd0);
        check_frame("two_f1", s + 360, 32'h0000_0004, 32'h0010_0093);
        chk("two_idle_after", count_zeros(s + 720), 32'd0);

        // Three retires in one frame time: third dropped
        txlog.delete();
        pulse(32'h0000_0100, 32'h1111_2222);
        repeat (4) tick();
        pulse(32'h0000_0104, 32'h3333_4444);
        chk("three_drop_before", {24'd0, drop_count}, 32'd0);
        repeat (4) tick();
        pulse(32'h0000_0108, 32'h5555_6666);
        chk("three_drop_after", {24'd0, drop_count}, 32'd1);
        repeat (740) tick();
        chk("three_busy_end", {31'd0, busy}, 32'd0);
        s = find_start();
        if (s < 0) s = 0;
        check_frame("three_f0", s, 32'h0000_0100, 32'h1111_2222);
        check_frame("three_f1", s + 360, 32'h0000_0104, 32'h3333_4444);
        chk("three_no_third", count_zeros(s + 720), 32'd0);

        // Pending full while the frame ends in the same cycle: nothing dropped
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        txlog.delete();
        pulse(32'h0000_0200, 32'hAAAA_0001);
        repeat (4) tick();
        pulse(32'h0000_0204, 32'hAAAA_0002);
        repeat (355) tick();
        pulse(32'h0000_0208, 32'hAAAA_0003);
        chk("edge_drop", {24'd0, drop_count}, 32'd0);
        chk("edge_busy", {31'd0, busy}, 32'd1);
        repeat (1100) tick();
        chk("edge_busy_end", {31'd0, busy}, 32'd0);
        s = find_start();
        if (s < 0) s = 0;
        check_frame("edge_f0", s, 32'h0000_0200, 32'hAAAA_0001);
        check_frame("edge_f1", s + 360, 32'h0000_0204, 32'hAAAA_0002);
        check_frame("edge_f2", s + 720, 32'h0000_0208, 32'hAAAA_0003);

        // 300 overflow drops: saturation at 255
        retire_pc    = 32'h0000_0300;
        retire_instr = 32'h0000_0013;
        retire_valid = 1'b1;
        repeat (256) tick();
        chk("sat_254", {24'd0, drop_count}, 32'd254);
        tick();
        chk("sat_255", {24'd0, drop_count}, 32'd255);
        repeat (45) tick();
        retire_valid = 1'b0;
        chk("sat_hold", {24'd0, drop_count}, 32'd255);
        repeat (800) tick();
        chk("sat_busy_end", {31'd0, busy}, 32'd0);
        chk("sat_final", {24'd0, drop_count}, 32'd255);

        // Reset in the middle of pc byte 2, with a frame pending
        pulse(32'h0000_0000, 32'h0000_0000);
        repeat (4) tick();
        pulse(32'h0000_0010, 32'h0000_0000);
        repeat (86) tick();
        chk("rst_mid_tx", {31'd0, tx}, 32'd0);
        rst_n = 1'b0;
        tick();
        chk("rst_tx", {31'd0, tx}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_drop", {24'd0, drop_count}, 32'd0);
        rst_n = 1'b1;
        txlog.delete();
        repeat (400) tick();
        chk("rst_no_bytes", count_zeros(0), 32'd0);
        chk("rst_busy_after", {31'd0, busy}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
